// File: rtl/ulx3s_pll_reset_seq_if.sv
// ulx3s_pll_reset_seq_if: lock input and reset/status outputs of one PLL clock domain.
// The master modport belongs to the sequencer; the slave modport belongs to the PLL/consumer side.
interface ulx3s_pll_reset_seq_if;
    logic       pll_locked;
    logic       rst_out;
    logic       ready;
    logic       lost_lock;
    logic [7:0] loss_count;

    modport master (
        input  pll_locked,
        output rst_out,
        output ready,
        output lost_lock,
        output loss_count
    );

    modport slave (
        output pll_locked,
        input  rst_out,
        input  ready,
        input  lost_lock,
        input  loss_count
    );
endinterface

// File: rtl/ulx3s_pll_reset_seq.sv
// ulx3s_pll_reset_seq: synchronises and debounces a PLL lock, then releases a domain reset.
// Define ULX3S_PLL_RESET_SEQ_LOSS_COUNT_EN to build the saturating lock-loss counter.
module ulx3s_pll_reset_seq #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 256
) (
    input  logic                     clock,
    input  logic                     reset,
    ulx3s_pll_reset_seq_if.master    bus
);
    localparam int MAXC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, RUN, HOLD} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   locked_s;
    logic                   rst_q;
    logic                   ready_q;
    logic                   lost_q;

    assign locked_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], bus.pll_locked};
    end

    // Outputs are registered alongside the state so they change on the transition edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            rst_q   <= 1'b1;
            ready_q <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            lost_q <= 1'b0;
            case (state)
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= STABILIZE;
                        cnt   <= '0;
                    end
                end
                STABILIZE: begin
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state   <= RUN;
                        cnt     <= '0;
                        rst_q   <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state   <= HOLD;
                        cnt     <= '0;
                        rst_q   <= 1'b1;
                        ready_q <= 1'b0;
                        lost_q  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= WAIT_LOCK;
                    cnt     <= '0;
                    rst_q   <= 1'b1;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rst_out   = rst_q;
    assign bus.ready     = ready_q;
    assign bus.lost_lock = lost_q;

`ifdef ULX3S_PLL_RESET_SEQ_LOSS_COUNT_EN
    logic [7:0] loss_q;

    // Counts on the same edge as the lost_lock pulse; survives relock, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                            loss_q <= '0;
        else if (state == RUN && !locked_s && loss_q != 8'hff) loss_q <= loss_q + 8'd1;
    end

    assign bus.loss_count = loss_q;
`else
    assign bus.loss_count = 8'd0;
`endif
endmodule

// File: tb/tb_ulx3s_pll_reset_seq.sv
// tb_ulx3s_pll_reset_seq: directed plus randomized lock stimulus against a streak/hold-time model.
// The model tracks consecutive synchronised-lock cycles and remaining hold time, not FSM states.
module tb_ulx3s_pll_reset_seq;
    localparam int S  = 2;
    localparam int ST = 16;
    localparam int H  = 8;

    logic clock;
    logic reset;
    bit   chk_on;
    int   n_cmp;
    int   n_err;

    ulx3s_pll_reset_seq_if bus();

    ulx3s_pll_reset_seq #(
        .SYNC_STAGES  (S),
        .STABLE_CYCLES(ST),
        .HOLD_CYCLES  (H)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clock = ~clock;

    // Model: lock samples delayed S edges; RUN after ST+1 consecutive locked samples; H-cycle hold.
    bit q[$];
    bit running;
    bit m_pulse;
    int hold_left;
    int streak;
    int m_loss;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q = {};
            for (int i = 0; i < S; i++) q.push_back(1'b0);
            running = 0; m_pulse = 0; hold_left = 0; streak = 0; m_loss = 0;
        end else begin
            bit ls;
            ls = q.pop_front();
            q.push_back(bus.pll_locked);
            m_pulse = 0;
            if (running) begin
                if (!ls) begin
                    running = 0;
                    hold_left = H;
                    m_pulse = 1;
                    if (m_loss < 255) m_loss++;
                end
            end else if (hold_left > 0) begin
                hold_left--;
            end else if (ls) begin
                streak++;
                if (streak == ST + 1) begin
                    running = 1;
                    streak = 0;
                end
            end else begin
                streak = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        int exp_loss;
        #1;
        if (chk_on) begin
`ifdef ULX3S_PLL_RESET_SEQ_LOSS_COUNT_EN
            exp_loss = m_loss;
`else
            exp_loss = 0;
`endif
            chk("model_rst_out", int'(bus.rst_out), int'(!running));
            chk("model_ready", int'(bus.ready), int'(running));
            chk("model_lost_lock", int'(bus.lost_lock), int'(m_pulse));
            chk("model_loss_count", int'(bus.loss_count), exp_loss);
        end
    end

    task automatic lose_once();
        @(negedge clock) bus.pll_locked = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clock);
        bus.pll_locked = 1'b1;
        repeat (40) @(negedge clock);
    endtask

    task automatic reset_pulse();
        @(negedge clock) reset = 1'b1;
        @(negedge clock) reset = 1'b0;
    endtask

    initial begin
        bit seen_lost;
        bit seen_ready;
        int exp3;
        int exp255;
        clock = 0;
        bus.pll_locked = 1'b1;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1 chk_on = 1;
        chk("reset_rst_out", int'(bus.rst_out), 1);
        chk("reset_ready", int'(bus.ready), 0);
        chk("reset_loss_count", int'(bus.loss_count), 0);
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b0;

        // Lock held from reset release: release on edge S+ST+1.
        for (int e = 1; e <= 19; e++) begin
            @(posedge clock); #1;
            if (e == 18) chk("t1_rst_e18", int'(bus.rst_out), 1);
            if (e == 19) begin
                chk("t1_rst_e19", int'(bus.rst_out), 0);
                chk("t1_ready_e19", int'(bus.ready), 1);
                chk("t1_lost_e19", int'(bus.lost_lock), 0);
            end
        end

        // One-cycle lock drop in RUN.
        @(negedge clock) bus.pll_locked = 1'b0;
        @(negedge clock) bus.pll_locked = 1'b1;
        for (int e = 2; e <= 28; e++) begin
            @(posedge clock); #1;
            if (e == 2) chk("t3_ready_e2", int'(bus.ready), 1);
            if (e == 3) begin
                chk("t3_rst_e3", int'(bus.rst_out), 1);
                chk("t3_lost_e3", int'(bus.lost_lock), 1);
            end
            if (e == 4) chk("t3_lost_e4", int'(bus.lost_lock), 0);
            if (e == 27) chk("t3_rst_e27", int'(bus.rst_out), 1);
            if (e == 28) chk("t3_rst_e28", int'(bus.rst_out), 0);
        end

        // Asynchronous reset in RUN between edges.
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("t4_async_rst", int'(bus.rst_out), 1);
        chk("t4_async_ready", int'(bus.ready), 0);
        @(negedge clock);
        @(negedge clock) reset = 1'b0;
        for (int e = 1; e <= 19; e++) begin
            @(posedge clock); #1;
            if (e == 18) chk("t4_rst_e18", int'(bus.rst_out), 1);
            if (e == 19) chk("t4_rst_e19", int'(bus.rst_out), 0);
        end

        // Glitch during STABILIZE at cnt==10.
        reset_pulse();
        seen_lost = 0;
        for (int e = 1; e <= 32; e++) begin
            @(posedge clock); #1;
            seen_lost |= bus.lost_lock;
            if (e == 19) chk("t2_rst_e19", int'(bus.rst_out), 1);
            if (e == 31) chk("t2_rst_e31", int'(bus.rst_out), 1);
            if (e == 32) begin
                chk("t2_rst_e32", int'(bus.rst_out), 0);
                chk("t2_no_lost", int'(seen_lost), 0);
            end
            if (e == 12) @(negedge clock) bus.pll_locked = 1'b0;
            if (e == 13) @(negedge clock) bus.pll_locked = 1'b1;
        end

        // Loss counting and saturation.
`ifdef ULX3S_PLL_RESET_SEQ_LOSS_COUNT_EN
        exp3 = 3; exp255 = 255;
`else
        exp3 = 0; exp255 = 0;
`endif
        for (int i = 0; i < 3; i++) lose_once();
        chk("t5_loss3", int'(bus.loss_count), exp3);
        chk("t5_ready_after_relock", int'(bus.ready), 1);
        for (int i = 0; i < 297; i++) lose_once();
        chk("t5_loss300", int'(bus.loss_count), exp255);

        // Lock toggling every cycle never releases reset.
        reset_pulse();
        seen_ready = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock) bus.pll_locked = ~bus.pll_locked;
            seen_ready |= bus.ready;
        end
        chk("t6_never_ready", int'(seen_ready), 0);
        chk("t6_rst_held", int'(bus.rst_out), 1);

        // Random lock runs.
        reset_pulse();
        for (int i = 0; i < 120; i++) begin
            bit v;
            v = ($urandom_range(0, 3) != 0);
            @(negedge clock) bus.pll_locked = v;
            repeat (v ? $urandom_range(1, 40) : $urandom_range(1, 12)) @(negedge clock);
        end

        @(negedge clock);
        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
